ntt_butterfly_unit: RTL
=======================

# ntt_butterfly_unit

Parametrised, fully pipelined NTT butterfly for the NewHope datapath. It is the successor to the single-direction Gentleman-Sande butterfly. One beat per enabled cycle produces both butterfly outputs, fully reduced to [0, Q). A per-beat `mode` bit selects a forward Cooley-Tukey or an inverse Gentleman-Sande butterfly, and Montgomery reduction is built in. The block sits between the NTT coefficient RAM read port and the write-back path of the NTT controller.

## Interface
- `W`, 16: coefficient and twiddle width.
- `Q`, 12289: modulus. Must be odd, with Q < 2^(W-1).
- `R`, 18: Montgomery radix exponent. Must satisfy R >= W.
- `QINV`, 12287: −Q^-1 mod 2^R.
- `TAG_W`, 8: sideband tag width. Only used when `NTT_BFLY_TAG_EN` is defined.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `en`  in  1  global pipeline advance. When low, all state holds.
- `load`  in  1  input beat valid. Sampled only when `en` is high.
- `mode`  in  1  0 = GS (inverse), 1 = CT (forward). Captured per beat.
- `a`  in  W  even coefficient, in [0, Q).
- `a_pair`  in  W  odd coefficient, in [0, Q).
- `omega`  in  W  twiddle in the Montgomery domain, in [0, Q).
- `b`  out  W  even result.
- `b_pair`  out  W  odd result.
- `valid`  out  1  result beat valid.
- `tag_in`  in  TAG_W  only with the macro.
- `tag_out`  out  TAG_W  only with the macro.

## Operation
- mont(p) = p·2^-R mod Q, always returned in [0, Q).
- **CT beat:** t = mont(a_pair·omega); b = (a + t) mod Q; b_pair = (a − t) mod Q.
- **GS beat:** b = (a + a_pair) mod Q; b_pair = mont(((a − a_pair) mod Q)·omega).
- **Stage S1:**
  - s = a + a_pair, minus Q if ≥ Q.
  - d = a + Q − a_pair, minus Q if ≥ Q.
  - Multiplier operand x = mode ? a_pair : d.
  - Bypass operand y = mode ? a : s.
  - Internal width W+1.
- **Stage S2:** p = x·omega, 2W bits.
- **Stage S3:** m = (p[R-1:0]·QINV) mod 2^R.
- **Stage S4:** u = (p + m·Q) >> R. The sum is held in 2W+2 bits, and u < 2Q.
- **Stage S5:** r = u ≥ Q ? u − Q : u.
- **Stage S6 (output registers):**
  - CT: b = (y + r) mod Q; b_pair = (y + Q − r) mod Q.
  - GS: b = y; b_pair = r.
- `load`, `mode`, and the tag travel with the data in every stage.
- Beats with `load` = 0 are bubbles. They propagate and produce `valid` = 0.
- Bubbles and valid beats may interleave arbitrarily. Mixed modes in consecutive beats are legal and produce no hazard.
- Input values ≥ Q give undefined results. The verification bench must not drive them.

## Timing
- Latency is 6 enabled cycles.
  - A beat sampled at edge k (en = 1) appears on `b`, `b_pair`, `valid` after edge k+6, provided en = 1 on every intervening edge.
- Throughput is 1 beat per enabled cycle. There is no backpressure beyond `en`.
- **`en` = 0:** every register holds, including `valid`. A valid output therefore stays asserted, unchanged, for the whole stall.
- **Reset:**
  - `valid`, `b`, `b_pair`, and `tag_out` are 0.
  - All stage-valid bits are 0.
  - Data registers in S1–S5 may also be cleared.
- Reset has priority over `en`.
- Reset mid-operation discards every in-flight beat; no partial beat emerges.
- With `reset` and `load` both asserted, the beat is dropped.
- After reset deasserts, the first beat loaded appears 6 enabled cycles later.

## Configuration
- **`NTT_BFLY_TAG_EN` defined:**
  - The `tag_in` / `tag_out` ports exist.
  - The tag is captured with each beat and delayed through all 6 stages alongside `valid`.
  - The tag holds on `en` = 0 and resets to 0.
- **`NTT_BFLY_TAG_EN` undefined:**
  - The ports and tag registers are absent.
  - Datapath behaviour and latency are identical.

## Test plan
- **CT, Montgomery-one twiddle:** mode = 1, a = 100, a_pair = 50, omega = 4075 (2^18 mod Q) → after 6 cycles b = 150, b_pair = 50, valid = 1 for one cycle.
- **GS, negative difference:** mode = 0, a = 50, a_pair = 100, omega = 4075 → b = 150, b_pair = 12239.
- **CT wrap:** mode = 1, a = 12000, a_pair = 1000, omega = 4075 → b = 711, b_pair = 11000.
- **CT radix-scaled twiddle:** mode = 1, a = 0, a_pair = 4075, omega = 1 → b = 1, b_pair = 12288.
- **Back-to-back stream with stall:**
  - Stimulus: 8 consecutive beats of alternating mode, with 2 bubbles inserted, then `en` = 0 for 3 cycles mid-stream.
  - Required: outputs match the reference model in order, valid holds during the stall, and there are no duplicated or lost beats.
- **Reset mid-stream:**
  - Stimulus: load 4 beats, then assert reset on cycle 3 for 1 cycle.
  - Required: valid stays 0 and all outputs stay 0 until a new post-reset beat completes 6 cycles later.
  - With `NTT_BFLY_TAG_EN`, tag_out also equals 0 until that beat arrives, then equals its tag.

Source files
------------

// File: rtl/ntt_butterfly_unit_if.sv
// ntt_butterfly_unit_if: beat-level bus between the NTT coefficient RAM read
// port / controller (master) and the butterfly unit (slave).
// Optional sideband tag signals exist only when NTT_BFLY_TAG_EN is defined.
interface ntt_butterfly_unit_if #(
    parameter int W     = 16,
    parameter int TAG_W = 8
);
    logic         en;
    logic         load;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] a_pair;
    logic [W-1:0] omega;
    logic [W-1:0] b;
    logic [W-1:0] b_pair;
    logic         valid;
`ifdef NTT_BFLY_TAG_EN
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output en, load, mode, a, a_pair, omega, tag_in,
        input  b, b_pair, valid, tag_out
    );
    modport slave (
        input  en, load, mode, a, a_pair, omega, tag_in,
        output b, b_pair, valid, tag_out
    );
`else
    modport master (
        output en, load, mode, a, a_pair, omega,
        input  b, b_pair, valid
    );
    modport slave (
        input  en, load, mode, a, a_pair, omega,
        output b, b_pair, valid
    );
`endif
endinterface

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit: fully pipelined NTT butterfly with per-beat mode select
// (1 = forward Cooley-Tukey, 0 = inverse Gentleman-Sande) and built-in
// Montgomery reduction. Results are fully reduced to [0, Q).
// Latency: 6 enabled cycles (input capture, S1 add/sub, S2 multiply,
// S3 Montgomery factor, S4 Montgomery shift, S5 final subtract, S6 outputs).
// Optional feature macro: NTT_BFLY_TAG_EN adds a sideband tag that travels
// with each beat.
module ntt_butterfly_unit #(
    parameter int W     = 16,
    parameter int Q     = 12289,
    parameter int R     = 18,
    parameter int QINV  = 12287,
    parameter int TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    ntt_butterfly_unit_if.slave      bus
);
    localparam int              SW      = 2 * W + 2;
    localparam logic [W:0]      LP_Q1   = (W + 1)'(Q);
    localparam logic [R-1:0]    LP_QINV = R'(QINV);
    localparam logic [SW-1:0]   LP_QS   = SW'(Q);

    // Per-stage beat valid and mode; index 0 is the input capture stage.
    logic [5:0]   r_vld;
    logic [5:0]   r_mode;

    // Stage 0: raw captured operands.
    logic [W-1:0] r_s0_a;
    logic [W-1:0] r_s0_ap;
    logic [W-1:0] r_s0_om;
    // Stage 1: multiplier operand, bypass operand, twiddle.
    logic [W-1:0] r_s1_x;
    logic [W-1:0] r_s1_y;
    logic [W-1:0] r_s1_om;
    // Stage 2: full product.
    logic [2*W-1:0] r_s2_p;
    logic [W-1:0]   r_s2_y;
    // Stage 3: product plus Montgomery factor.
    logic [2*W-1:0] r_s3_p;
    logic [R-1:0]   r_s3_m;
    logic [W-1:0]   r_s3_y;
    // Stage 4: unreduced Montgomery result, u < 2Q.
    logic [W:0]     r_s4_u;
    logic [W-1:0]   r_s4_y;
    // Stage 5: reduced Montgomery result.
    logic [W-1:0]   r_s5_r;
    logic [W-1:0]   r_s5_y;

    // Output registers.
    logic [W-1:0] r_b;
    logic [W-1:0] r_bp;
    logic         r_valid;

    // Combinational stage logic.
    logic [W:0]     w_s_sum;
    logic [W:0]     w_d_sum;
    logic [W-1:0]   w_s;
    logic [W-1:0]   w_d;
    logic [W-1:0]   w_x;
    logic [W-1:0]   w_y;
    logic [SW-1:0]  w_mq_sum;
    logic [W:0]     w_u;
    logic [W-1:0]   w_r;
    logic [W:0]     w_ct_add;
    logic [W:0]     w_ct_sub;
    logic [W-1:0]   w_b;
    logic [W-1:0]   w_bp;

    // S1 modular add/subtract and operand steering by mode.
    always_comb begin
        w_s_sum = {1'b0, r_s0_a} + {1'b0, r_s0_ap};
        w_d_sum = {1'b0, r_s0_a} + LP_Q1 - {1'b0, r_s0_ap};
        if (w_s_sum >= LP_Q1) begin
            w_s = W'(w_s_sum - LP_Q1);
        end else begin
            w_s = w_s_sum[W-1:0];
        end
        if (w_d_sum >= LP_Q1) begin
            w_d = W'(w_d_sum - LP_Q1);
        end else begin
            w_d = w_d_sum[W-1:0];
        end
        if (r_mode[0]) begin
            w_x = r_s0_ap;
            w_y = r_s0_a;
        end else begin
            w_x = w_d;
            w_y = w_s;
        end
    end

    // S4 Montgomery sum/shift and S5 conditional subtract of Q.
    always_comb begin
        w_mq_sum = SW'(r_s3_p) + SW'(r_s3_m) * LP_QS;
        w_u      = (W + 1)'(w_mq_sum >> R);
        if (r_s4_u >= LP_Q1) begin
            w_r = W'(r_s4_u - LP_Q1);
        end else begin
            w_r = r_s4_u[W-1:0];
        end
    end

    // S6 final combine: CT adds/subtracts the twiddled term, GS passes through.
    always_comb begin
        w_ct_add = {1'b0, r_s5_y} + {1'b0, r_s5_r};
        w_ct_sub = {1'b0, r_s5_y} + LP_Q1 - {1'b0, r_s5_r};
        if (r_mode[5]) begin
            if (w_ct_add >= LP_Q1) begin
                w_b = W'(w_ct_add - LP_Q1);
            end else begin
                w_b = w_ct_add[W-1:0];
            end
            if (w_ct_sub >= LP_Q1) begin
                w_bp = W'(w_ct_sub - LP_Q1);
            end else begin
                w_bp = w_ct_sub[W-1:0];
            end
        end else begin
            w_b  = r_s5_y;
            w_bp = r_s5_r;
        end
    end

    // Beat valid/mode shift register; bubbles travel as valid = 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= 6'd0;
            r_mode <= 6'd0;
        end else if (bus.en) begin
            r_vld  <= {r_vld[4:0], bus.load};
            r_mode <= {r_mode[4:0], bus.mode};
        end
    end

    // Datapath stage registers; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_a  <= '0;
            r_s0_ap <= '0;
            r_s0_om <= '0;
            r_s1_x  <= '0;
            r_s1_y  <= '0;
            r_s1_om <= '0;
            r_s2_p  <= '0;
            r_s2_y  <= '0;
            r_s3_p  <= '0;
            r_s3_m  <= '0;
            r_s3_y  <= '0;
            r_s4_u  <= '0;
            r_s4_y  <= '0;
            r_s5_r  <= '0;
            r_s5_y  <= '0;
        end else if (bus.en) begin
            r_s0_a  <= bus.a;
            r_s0_ap <= bus.a_pair;
            r_s0_om <= bus.omega;
            r_s1_x  <= w_x;
            r_s1_y  <= w_y;
            r_s1_om <= r_s0_om;
            r_s2_p  <= (2 * W)'(r_s1_x) * (2 * W)'(r_s1_om);
            r_s2_y  <= r_s1_y;
            r_s3_p  <= r_s2_p;
            r_s3_m  <= R'(r_s2_p[R-1:0] * LP_QINV);
            r_s3_y  <= r_s2_y;
            r_s4_u  <= w_u;
            r_s4_y  <= r_s3_y;
            r_s5_r  <= w_r;
            r_s5_y  <= r_s4_y;
        end
    end

    // Output registers update only on valid beats so bubbles leave results held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_b     <= '0;
            r_bp    <= '0;
        end else if (bus.en) begin
            r_valid <= r_vld[5];
            if (r_vld[5]) begin
                r_b  <= w_b;
                r_bp <= w_bp;
            end
        end
    end

    assign bus.b      = r_b;
    assign bus.b_pair = r_bp;
    assign bus.valid  = r_valid;

`ifdef NTT_BFLY_TAG_EN
    logic [TAG_W-1:0] r_tag [6];
    logic [TAG_W-1:0] r_tag_out;

    // Sideband tag delay line, aligned with the beat valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                r_tag[i] <= '0;
            end
            r_tag_out <= '0;
        end else if (bus.en) begin
            r_tag[0] <= bus.tag_in;
            for (int i = 1; i < 6; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (r_vld[5]) begin
                r_tag_out <= r_tag[5];
            end
        end
    end

    assign bus.tag_out = r_tag_out;
`endif

endmodule
